ram_be_wr_pack: RTL and testbench

Byte-stream write packer that sits directly upstream of the byte-enable dual-port RAM and drives one of its ports. It takes a command (start byte address, byte length) and a valid/ready stream of 8-bit pixels. It packs the pixels little-endian into RAM words and issues one RAM write per completed or final partial word, with active-low byte write enables. Line-buffer and reconstruction-buffer writers use it so that no client has to handle misaligned rows.

---
 rtl/ram_be_wr_pack_pkg.sv | 21 ++
 rtl/ram_be_wr_pack_if.sv | 39 +++
 rtl/ram_be_wr_pack.sv | 135 +++++++++++++
 tb/tb_ram_be_wr_pack.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_be_wr_pack_pkg.sv
`default_nettype none
// ============================================================================
// ram_be_wr_pack_pkg : shared types and helpers for the byte-stream packer
// Revision: 1.0
// ============================================================================
package ram_be_wr_pack_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_be_wr_pack_if.sv
`default_nettype none
// ============================================================================
// ram_be_wr_pack_if : command, pixel stream and RAM write port of the packer
// Revision: 1.0
// ============================================================================
interface ram_be_wr_pack_if
    import ram_be_wr_pack_pkg::*;
#(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8
);
    localparam int Byte_Width = Word_Width >> 3;
    localparam int BA_W       = Addr_Width + clog2(Byte_Width);

    logic                  start_i;
    logic [BA_W-1:0]       baddr_i;
    logic [BA_W:0]         len_i;
    logic                  pix_val_i;
    logic [7:0]            pix_i;
    logic                  pix_rdy_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  cen_o;
    logic [Byte_Width-1:0] wen_o;
    logic [Addr_Width-1:0] addr_o;
    logic [Word_Width-1:0] data_o;

    modport slave (
        input  start_i, baddr_i, len_i, pix_val_i, pix_i,
        output pix_rdy_o, busy_o, done_o, cen_o, wen_o, addr_o, data_o
    );

    modport master (
        output start_i, baddr_i, len_i, pix_val_i, pix_i,
        input  pix_rdy_o, busy_o, done_o, cen_o, wen_o, addr_o, data_o
    );

endinterface
`default_nettype wire

// File: rtl/ram_be_wr_pack.sv
`default_nettype none
// ============================================================================
// ram_be_wr_pack : packs a byte stream little-endian into byte-enabled RAM writes
// Revision: 1.0
// ============================================================================
module ram_be_wr_pack
    import ram_be_wr_pack_pkg::*;
#(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ram_be_wr_pack_if.slave bus
);
    localparam int Byte_Width = Word_Width >> 3;
    localparam int BS         = clog2(Byte_Width);
    localparam int BA_W       = Addr_Width + BS;

    state_t                state_q, state_d;
    logic [BA_W-1:0]       bp_q, bp_d;
    logic [BA_W:0]         rem_q, rem_d;
    logic [Word_Width-1:0] acc_q, acc_d;
    logic [Byte_Width-1:0] mask_q, mask_d;
    logic                  cen_q, cen_d;
    logic [Byte_Width-1:0] wen_q, wen_d;
    logic [Addr_Width-1:0] addr_q, addr_d;
    logic [Word_Width-1:0] data_q, data_d;
    logic                  done_q, done_d;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_flush;
    logic [BS-1:0]         w_lane;
    logic [Byte_Width-1:0] w_mask_m;
    logic [Word_Width-1:0] w_acc_m;

    assign w_accept = (state_q == ST_FILL) && bus.pix_val_i;
    assign w_lane   = bp_q[BS-1:0];
    assign w_last   = (rem_q == (BA_W+1)'(1));
    assign w_flush  = w_accept && ((&w_lane) || w_last);
    assign w_mask_m = mask_q | (Byte_Width'(1) << w_lane);

    // Accumulator lanes are cleared on every flush, so unwritten lanes stay zero.
    always_comb begin
        w_acc_m = acc_q;
        for (int i = 0; i < Byte_Width; i++) begin
            if (w_lane == BS'(i)) w_acc_m[8*i +: 8] = bus.pix_i;
        end
    end

    always_comb begin
        state_d = state_q;
        bp_d    = bp_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        cen_d   = 1'b1;
        wen_d   = '1;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    bp_d   = bus.baddr_i;
                    rem_d  = bus.len_i;
                    acc_d  = '0;
                    mask_d = '0;
                    if (bus.len_i == '0) done_d = 1'b1;
                    else                 state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    bp_d  = bp_q + BA_W'(1);
                    rem_d = rem_q - (BA_W+1)'(1);
                    if (w_flush) begin
                        cen_d  = 1'b0;
                        wen_d  = ~w_mask_m;
                        addr_d = bp_q[BA_W-1:BS];
                        data_d = w_acc_m;
                        acc_d  = '0;
                        mask_d = '0;
                    end else begin
                        acc_d  = w_acc_m;
                        mask_d = w_mask_m;
                    end
                    if (w_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bp_q    <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
            cen_q   <= 1'b1;
            wen_q   <= '1;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bp_q    <= bp_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.pix_rdy_o = (state_q == ST_FILL);
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.done_o    = done_q;
    assign bus.cen_o     = cen_q;
    assign bus.wen_o     = wen_q;
    assign bus.addr_o    = addr_q;
    assign bus.data_o    = data_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_be_wr_pack.sv
`default_nettype none
// ============================================================================
// tb_ram_be_wr_pack : directed vectors with a queue scoreboard on the RAM port
// Revision: 1.0
// ============================================================================
module tb_ram_be_wr_pack;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [3:0]  wen;
        logic [31:0] data;
        logic        dn;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t q[$];

    ram_be_wr_pack_if #(.Word_Width(32), .Addr_Width(8)) bus ();

    ram_be_wr_pack #(.Word_Width(32), .Addr_Width(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic void exp_w(input logic [7:0] a, input logic [3:0] w,
                                  input logic [31:0] d, input logic dn);
        exp_t e;
        e.wr = 1'b1; e.addr = a; e.wen = w; e.data = d; e.dn = dn;
        q.push_back(e);
    endfunction

    function automatic void exp_done_only();
        exp_t e;
        e.wr = 1'b0; e.addr = '0; e.wen = '1; e.data = '0; e.dn = 1'b1;
        q.push_back(e);
    endfunction

    // Monitor: every presented write or done pulse must match the queue head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && (bus.cen_o == 1'b0 || bus.done_o)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: cen=%0b done=%0b addr=0x%0h wen=%b data=0x%0h expected nothing",
                         bus.cen_o, bus.done_o, bus.addr_o, bus.wen_o, bus.data_o);
            end else begin
                e = q.pop_front();
                check("cen", {31'd0, bus.cen_o}, {31'd0, ~e.wr});
                check("done", {31'd0, bus.done_o}, {31'd0, e.dn});
                if (e.wr) begin
                    check("addr", {24'd0, bus.addr_o}, {24'd0, e.addr});
                    check("wen", {28'd0, bus.wen_o}, {28'd0, e.wen});
                    check("data", bus.data_o, e.data);
                end
            end
        end
    end

    task automatic do_start(input logic [9:0] ba, input logic [10:0] ln);
        bus.start_i = 1'b1;
        bus.baddr_i = ba;
        bus.len_i   = ln;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        if (ln != 11'd0) begin
            check("rdy_after_start", {31'd0, bus.pix_rdy_o}, 32'd1);
            check("busy_after_start", {31'd0, bus.busy_o}, 32'd1);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.pix_val_i = 1'b1;
        bus.pix_i     = b;
        while (!bus.pix_rdy_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL rdy_timeout: pix_rdy_o=%0b expected 1", bus.pix_rdy_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.pix_val_i = 1'b0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
        check("busy_idle", {31'd0, bus.busy_o}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start_i   = 1'b0;
        bus.baddr_i   = '0;
        bus.len_i     = '0;
        bus.pix_val_i = 1'b0;
        bus.pix_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", {31'd0, bus.pix_rdy_o}, 32'd0);
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_done", {31'd0, bus.done_o}, 32'd0);
        check("rst_cen", {31'd0, bus.cen_o}, 32'd1);
        check("rst_wen", {28'd0, bus.wen_o}, 32'hF);
        check("rst_addr", {24'd0, bus.addr_o}, 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Aligned, back-to-back
        exp_w(8'h04, 4'b0000, 32'h14131211, 1'b0);
        exp_w(8'h05, 4'b0000, 32'h18171615, 1'b1);
        do_start(10'h010, 11'd8);
        for (int i = 0; i < 8; i++) push_byte(8'h11 + 8'(i));
        drain();

        // Unaligned
        exp_w(8'h04, 4'b0111, 32'hAA000000, 1'b0);
        exp_w(8'h05, 4'b1100, 32'h0000CCBB, 1'b1);
        do_start(10'h013, 11'd3);
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        drain();

        // Wrap across the top of the byte space
        exp_w(8'hFF, 4'b0011, 32'h02010000, 1'b0);
        exp_w(8'h00, 4'b1100, 32'h00000403, 1'b1);
        do_start(10'h3FE, 11'd4);
        for (int i = 0; i < 4; i++) push_byte(8'h01 + 8'(i));
        drain();

        // Stalled stream: a single full-word write
        exp_w(8'h00, 4'b0000, 32'h44332211, 1'b1);
        do_start(10'h000, 11'd4);
        for (int i = 0; i < 4; i++) begin
            push_byte(8'h11 * 8'(i + 1));
            bus.pix_val_i = 1'b0;
            @(posedge clk); #1;
        end
        drain();

        // Zero length: done without a write
        exp_done_only();
        do_start(10'h055, 11'd0);
        drain();

        // Start while busy is ignored
        exp_w(8'h08, 4'b0000, 32'h34333231, 1'b1);
        do_start(10'h020, 11'd4);
        push_byte(8'h31);
        bus.start_i = 1'b1;
        bus.baddr_i = 10'h100;
        bus.len_i   = 11'd2;
        push_byte(8'h32);
        bus.start_i = 1'b0;
        push_byte(8'h33);
        push_byte(8'h34);
        drain();

        // Reset mid-command discards the partial word
        do_start(10'h000, 11'd4);
        push_byte(8'hE1);
        push_byte(8'hE2);
        bus.pix_val_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_cen", {31'd0, bus.cen_o}, 32'd1);
        check("midrst_rdy", {31'd0, bus.pix_rdy_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_w(8'h00, 4'b0000, 32'h24232221, 1'b1);
        do_start(10'h000, 11'd4);
        for (int i = 0; i < 4; i++) push_byte(8'h21 + 8'(i));
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
